// File: rtl/product_accumulator.sv
// Product accumulator: sums a batch of 1..16 unsigned multiplier products
// and presents the batch total downstream through a valid/ready handshake.
module product_accumulator #(
    parameter int unsigned PROD_W = 12,
    parameter int unsigned ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        len,
    input  logic              clr,
    output logic [ACC_W-1:0]  out_sum,
    output logic [4:0]        out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        batches
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [4:0]        cnt;
    logic [4:0]        target;

    logic              beat_ok;
    logic [4:0]        len_target;
    logic [ACC_W-1:0]  acc_sum;
    logic [4:0]        cnt_inc;

    // Beats are refused while a result is pending and during an abort.
    assign in_ready = (state != DONE) && !clr;

    // Next-value helpers shared by the IDLE and ACCUM branches.
    always_comb begin
        beat_ok    = in_valid && in_ready;
        len_target = (len == 4'd0) ? 5'd16 : {1'b0, len};
        acc_sum    = acc + ACC_W'(in_product);
        cnt_inc    = cnt + 5'd1;
    end

    // Batch FSM with registered result outputs; clr overrides every handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= 5'd0;
            target    <= 5'd1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= 5'd0;
            batches   <= 8'd0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= 5'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat_ok) begin
                        target <= len_target;
                        acc    <= ACC_W'(in_product);
                        cnt    <= 5'd1;
                        if (len_target == 5'd1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= ACC_W'(in_product);
                            out_count <= 5'd1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_ok) begin
                        acc <= acc_sum;
                        cnt <= cnt_inc;
                        if (cnt_inc == target) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= acc_sum;
                            out_count <= cnt_inc;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= 5'd0;
                        out_valid <= 1'b0;
                        batches   <= batches + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 12, giving the width of the incoming multiplier product.
REQ-002 SHALL have parameter ACC_W, default 16, giving the accumulator and result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_product, input, PROD_W bits: unsigned product from the upstream 6x6 multiplier.
REQ-006 SHALL have port in_valid, input, 1 bit: in_product is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port len, input, 4 bits: batch length in products; 0 encodes 16.
REQ-009 SHALL have port clr, input, 1 bit: synchronous abort of the current batch.
REQ-010 SHALL have port out_sum, output, ACC_W bits: completed batch sum.
REQ-011 SHALL have port out_count, output, 5 bits: number of products in out_sum (1..16).
REQ-012 SHALL have port out_valid, output, 1 bit: out_sum and out_count are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream block consumes the result.
REQ-014 SHALL have port batches, output, 8 bits: count of completed result handshakes.

Function
REQ-015 SHALL define a beat as accepted in any cycle where in_valid=1, in_ready=1 and clr=0.
REQ-016 SHALL define in_ready as (state != DONE) and (clr = 0), computed combinationally.
REQ-017 SHALL implement exactly three states: IDLE, ACCUM and DONE.
REQ-018 In IDLE, on an accepted beat, SHALL: latch target = (len==0 ? 16 : len); set acc = in_product zero-extended; set cnt = 1; move to DONE if target==1, otherwise to ACCUM.
REQ-019 In IDLE, SHALL ignore len when no beat is accepted.
REQ-020 In ACCUM, on an accepted beat, SHALL set acc = acc + in_product and cnt = cnt + 1, then move to DONE when the new cnt equals target.
REQ-021 In ACCUM, SHALL sample len only in IDLE, so a change of len mid-batch has no effect.
REQ-022 In DONE, SHALL drive out_valid=1 with out_sum=acc and out_count=cnt, holding both stable until out_ready=1.
REQ-023 In DONE, with out_ready=1, SHALL move to IDLE, clear acc and cnt, and increment batches (255 wraps to 0).
REQ-024 SHALL assert out_valid in the cycle after the last beat of a batch is accepted (latency 1 cycle).
REQ-025 SHALL accept no beat in DONE, including the cycle of the output handshake; the next batch starts in IDLE no earlier than the following cycle.
REQ-026 SHALL perform unsigned addition in ACC_W bits; with the defaults no overflow is possible (16 x 4095 = 65520).
REQ-027 SHALL give clr=1 priority over every handshake in any state: next state IDLE, acc=0, cnt=0, out_valid=0, batches unchanged, and no beat accepted that cycle.
REQ-028 SHALL not increment batches when clr=1 arrives in DONE, even if out_ready=1 in the same cycle.
REQ-029 SHALL register out_sum, out_count and out_valid with no combinational path from in_product.

Reset
REQ-030 While rst=1, SHALL force state=IDLE, acc=0, cnt=0, target=1, out_valid=0, out_sum=0, out_count=0 and batches=0, independent of clk.
REQ-031 SHALL take reset asserted mid-batch or in DONE immediately, discarding the partial or pending result.
REQ-032 SHALL hold in_ready=1 during reset because the state is IDLE; beats presented while rst=1 SHALL be discarded.
REQ-033 SHALL begin operation on the first rising clk edge after rst falls.

Verification
REQ-034 Scenario 1 SHALL drive len=3 and beats 100, 200, 300 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the third beat, out_sum=600, out_count=3, then batches=1.
REQ-035 Scenario 2 SHALL drive len=0 and sixteen beats of 4095 -> out_sum=65520, out_count=16.
REQ-036 Scenario 3 SHALL drive len=1 and beat 3969 with out_ready=0 for 5 cycles -> out_valid held with out_sum=3969, in_ready=0 throughout; after out_ready=1, IDLE and batches incremented.
REQ-037 Scenario 4 SHALL drive len=4, accept 2 beats, then pulse clr with in_valid=1 -> the beat is not accepted, a new len=2 batch of 5 and 7 yields out_sum=12, and batches is unchanged by the clr.
REQ-038 Scenario 5 SHALL assert rst asynchronously (between edges) while in DONE -> out_valid, out_sum and batches go to 0 immediately.
REQ-039 Scenario 6 SHALL complete 256 len=1 batches -> batches wraps from 255 to 0.
